// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serializing arbiter between fetch and data requesters on one memory port
module mem_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

    state_t     state;
    logic       owner;
    logic [3:0] streak;
    logic       fetch_wins;

    // Data has priority (older instruction) unless fetch has waited through a full streak
    assign fetch_wins = if_req & (~d_req | (streak == MAX_STREAK));

    // Stalls drop combinationally in the done cycle so the pipeline advances on that edge
    assign if_stall = if_req & ~if_done;
    assign d_stall  = d_req & ~d_done;

    // Arbitration, memory handshake and response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            streak    <= 4'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if_done <= 1'b0;
                    d_done  <= 1'b0;
                    if (!if_req) begin
                        streak <= 4'd0;
                    end
                    if (if_req || d_req) begin
                        state   <= BUSY;
                        mem_req <= 1'b1;
                        if (fetch_wins) begin
                            owner    <= 1'b0;
                            mem_addr <= if_addr;
                            mem_we   <= 1'b0;
                            streak   <= 4'd0;
                        end else begin
                            owner     <= 1'b1;
                            mem_addr  <= d_addr;
                            mem_we    <= d_we;
                            mem_wdata <= d_wdata;
                            if (if_req && (streak < MAX_STREAK)) begin
                                streak <= streak + 4'd1;
                            end
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        if (owner) begin
                            d_rdata <= mem_rdata;
                            d_done  <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_done  <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    // One quiet edge lets the served requester drop or replace its request
                    if_done <= 1'b0;
                    d_done  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks   = 0;
    int failures = 0;
    int streak_m = 0;

    mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_D_STREAK(MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_if();
        if_req  = 1'b1;
        if_addr = $urandom() & 32'hFFFF_FFFC;
    endtask

    task automatic new_d();
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = $urandom() & 32'hFFFF_FFFC;
        d_wdata = $urandom();
    endtask

    // One whole transaction from an IDLE cycle: grant, BUSY with waits, RESP, back to IDLE
    task automatic serve(input int waits, input logic [31:0] rd, input bit allow_late,
                         output bit fw);
        logic [31:0] ea;
        logic [31:0] ewd;
        logic        ewe;
        #1;
        check("idle_mem_req", mem_req, 0);
        check("idle_if_stall", if_stall, if_req);
        check("idle_d_stall", d_stall, d_req);
        fw = if_req && (!d_req || streak_m == MAX);
        if (fw) streak_m = 0;
        else if (if_req) streak_m = (streak_m < MAX) ? streak_m + 1 : MAX;
        else streak_m = 0;
        ea  = fw ? if_addr : d_addr;
        ewe = fw ? 1'b0 : d_we;
        ewd = d_wdata;
        for (int k = 0; k <= waits; k++) begin
            tick();
            check("busy_mem_req", mem_req, 1);
            check("busy_addr", mem_addr, ea);
            check("busy_we", mem_we, ewe);
            if (ewe) check("busy_wdata", mem_wdata, ewd);
            check("busy_if_done", if_done, 0);
            check("busy_d_done", d_done, 0);
            check("busy_if_stall", if_stall, if_req);
            check("busy_d_stall", d_stall, d_req);
            mem_ready = (k == waits);
            mem_rdata = (k == waits) ? rd : $urandom();
            if (allow_late && $urandom_range(0, 3) == 0) begin
                if (fw && !d_req) new_d();
                else if (!fw && !if_req) new_if();
            end
        end
        tick();
        mem_ready = 1'b0;
        check("resp_if_done", if_done, fw);
        check("resp_d_done", d_done, !fw);
        check("resp_mem_req", mem_req, 0);
        if (fw) begin
            check("resp_if_rdata", if_rdata, rd);
            check("resp_if_stall", if_stall, 0);
            check("resp_d_stall", d_stall, d_req);
            if_req = 1'b0;
        end else begin
            if (!ewe) check("resp_d_rdata", d_rdata, rd);
            check("resp_d_stall", d_stall, 0);
            check("resp_if_stall", if_stall, if_req);
            d_req = 1'b0;
        end
        tick();
        check("post_if_done", if_done, 0);
        check("post_d_done", d_done, 0);
        check("post_mem_req", mem_req, 0);
    endtask

    initial begin
        bit fw;
        int d_grants;
        rst = 1'b0;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        mem_rdata = 0; mem_ready = 0;
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_if_done", if_done, 0);
        check("rst_d_done", d_done, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Lone fetch, zero-wait memory
        if_req = 1; if_addr = 32'h40;
        serve(0, 32'h8C22_0004, 0, fw);
        check("lone_fetch_owner", fw, 1);

        // Load with one wait cycle
        d_req = 1; d_we = 0; d_addr = 32'h8; d_wdata = 0;
        serve(1, 32'h1234_5678, 0, fw);
        check("load_owner", fw, 0);

        // Store with three wait cycles
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        serve(3, $urandom(), 0, fw);

        // Simultaneous requests: data first, fetch next
        if_req = 1; if_addr = 32'h44;
        d_req = 1; d_we = 0; d_addr = 32'h200;
        serve(0, 32'hA5A5_0001, 0, fw);
        check("simul_first_data", fw, 0);
        serve(0, 32'hA5A5_0002, 0, fw);
        check("simul_then_fetch", fw, 1);

        // Starvation: both held, expect DDDDF DDDDF
        d_grants = 0;
        for (int i = 0; i < 10; i++) begin
            if (!if_req) new_if();
            if (!d_req) new_d();
            serve($urandom_range(0, 2), $urandom(), 0, fw);
            check("starve_seq", fw, (i % 5 == 4));
            if (!fw) d_grants++;
        end
        check("starve_d_grants", d_grants, 8);
        if_req = 0;
        d_req  = 0;
        tick();
        streak_m = 0;

        // Reset in the middle of a BUSY cycle
        d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = 32'h1111_2222;
        tick();
        mem_ready = 0;
        check("rb_busy_mem_req", mem_req, 1);
        #2;
        rst = 1'b0;
        #1;
        check("rb_mem_req", mem_req, 0);
        check("rb_mem_addr", mem_addr, 0);
        check("rb_d_done", d_done, 0);
        check("rb_if_done", if_done, 0);
        d_req = 0;
        if_req = 1; if_addr = 32'h80;
        @(posedge clk);
        #1;
        rst = 1'b1;
        streak_m = 0;
        serve(0, 32'h0BAD_F00D, 0, fw);
        check("rb_fetch_after", fw, 1);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            if (!if_req && $urandom_range(0, 1) == 1) new_if();
            if (!d_req && $urandom_range(0, 1) == 1) new_d();
            if (!if_req && !d_req) begin
                streak_m = 0;
                #1;
                check("rand_idle_mem_req", mem_req, 0);
                tick();
            end else begin
                serve($urandom_range(0, 3), $urandom(), 1, fw);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
